// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: parity modes, receiver states and the
// three-sample majority vote used for every bit decision.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin; both flops reset to RST_VAL.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: majority-vote bit sampling, glitch/break handling,
// framing/parity/overrun flags and a valid/ready output register.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 32,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned H     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

  logic                 rxs;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 s0_q, s1_q;
  logic                 samp_c, dec_c, load_c;

  logic [DATA_BITS-1:0] dout_q;
  logic                 valid_q, fe_q, pe_q, ovr_q, busy_q;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rxs)
  );

  // Third vote is taken live at H+1 so the decision lands on the following edge.
  assign samp_c = (cnt_q == CNT_W'(H + 1));
  assign dec_c  = majority3(s0_q, s1_q, rxs);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      if (cnt_q == CNT_W'(H - 1)) s0_q <= rxs;
      if (cnt_q == CNT_W'(H))     s1_q <= rxs;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    load_c  = 1'b0;

    // Bit timing runs freely across state changes, which happen mid-bit.
    if (state_q != IDLE && state_q != BREAK_WAIT) begin
      cnt_d = (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        ferr_d = 1'b0;
        perr_d = 1'b0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (samp_c) begin
          idx_d   = '0;
          state_d = dec_c ? IDLE : DATA;
        end
      end
      DATA: begin
        if (samp_c) begin
          shreg_d = {dec_c, shreg_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
          end
        end
      end
      uart_pkg::PARITY: begin
        if (samp_c) begin
          perr_d  = (PARITY == PAR_ODD) ? ~(^shreg_q ^ dec_c) : (^shreg_q ^ dec_c);
          state_d = STOP;
        end
      end
      STOP: begin
        if (samp_c) begin
          if (!dec_c) ferr_d = 1'b1;
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            load_c  = 1'b1;
            idx_d   = '0;
            state_d = (shreg_q == '0 && ferr_d) ? BREAK_WAIT : IDLE;
          end
        end
      end
      BREAK_WAIT: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: a load wins over a same-cycle consume.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (load_c) begin
        dout_q  <= shreg_q;
        fe_q    <= ferr_d;
        pe_q    <= perr_q;
        ovr_q   <= valid_q && !data_ready;
        valid_q <= 1'b1;
      end else if (valid_q && data_ready) begin
        valid_q <= 1'b0;
      end
      busy_q <= (state_d != IDLE);
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign frame_err  = fe_q;
  assign parity_err = pe_q;
  assign overrun    = ovr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed + randomized bench for uart_rx_frame: two default receivers, one
// even-parity and one odd-parity receiver (the parity pair shares one rx line).
module tb_uart_rx_frame;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_v    [4];
  logic       ready_v [4];
  logic [7:0] dout    [4];
  logic       dv      [4];
  logic       fe      [4];
  logic       pe      [4];
  logic       ov      [4];
  logic       bz      [4];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int rises    [4] = '{0, 0, 0, 0};
  int rise_cyc [4] = '{0, 0, 0, 0};
  logic dv_prev [4] = '{1'b0, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Records when each receiver's data_valid rises and how often.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      dv_prev[i] <= dv[i];
      if (dv[i] && !dv_prev[i]) begin
        rises[i]    <= rises[i] + 1;
        rise_cyc[i] <= cyc;
      end
    end
  end

  uart_rx_frame u_def (
    .clk(clk), .reset(rst_n), .rx(rx_v[0]), .data_out(dout[0]), .data_valid(dv[0]),
    .data_ready(ready_v[0]), .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ov[0]), .busy(bz[0])
  );

  uart_rx_frame u_def2 (
    .clk(clk), .reset(rst_n), .rx(rx_v[1]), .data_out(dout[1]), .data_valid(dv[1]),
    .data_ready(ready_v[1]), .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ov[1]), .busy(bz[1])
  );

  uart_rx_frame #(.PARITY(1)) u_even (
    .clk(clk), .reset(rst_n), .rx(rx_v[2]), .data_out(dout[2]), .data_valid(dv[2]),
    .data_ready(ready_v[2]), .frame_err(fe[2]), .parity_err(pe[2]), .overrun(ov[2]), .busy(bz[2])
  );

  uart_rx_frame #(.PARITY(2)) u_odd (
    .clk(clk), .reset(rst_n), .rx(rx_v[2]), .data_out(dout[3]), .data_valid(dv[3]),
    .data_ready(ready_v[3]), .frame_err(fe[3]), .parity_err(pe[3]), .overrun(ov[3]), .busy(bz[3])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge where cyc reaches target.
  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Drives one frame; per100 is the bit period in hundredths of a cycle.
  task automatic send(input int ch, input logic [7:0] d, input bit has_par,
                      input logic pbit, input int per100);
    int start;
    int nb;
    logic b;
    start = cyc;
    nb = has_par ? 11 : 10;
    for (int k = 0; k < nb; k++) begin
      if (k == 0)                    b = 1'b0;
      else if (k <= 8)               b = d[k-1];
      else if (has_par && k == 9)    b = pbit;
      else                           b = 1'b1;
      rx_v[ch] = b;
      wait_to(start + ((k + 1) * per100 + 50) / 100);
    end
    rx_v[ch] = 1'b1;
  endtask

  task automatic pulse(input int ch);
    ready_v[ch] = 1'b1;
    @(negedge clk);
    ready_v[ch] = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int r;
    logic [7:0] d;
    logic p;
    int ones;

    for (int i = 0; i < 4; i++) begin
      rx_v[i] = 1'b1;
      ready_v[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("reset_state_%0d", i), {dout[i], dv[i], fe[i], pe[i], ov[i], bz[i]}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Nominal 8N1 frame: value, flags and exact data_valid latency.
    t0 = cyc + 1;
    send(0, 8'hA5, 1'b0, 1'b0, 3200);
    chk("a5_rise_time", rise_cyc[0], t0 + 308);
    chk("a5_data", dout[0], 8'hA5);
    chk("a5_flags", {fe[0], pe[0], ov[0]}, 3'b000);
    repeat (20) @(negedge clk);
    chk("a5_held", dv[0], 1'b1);
    pulse(0);
    chk("a5_consumed", dv[0], 1'b0);
    chk("a5_data_kept", dout[0], 8'hA5);

    // Short low glitch must be rejected.
    r = rises[0];
    t0 = cyc + 1;
    rx_v[0] = 1'b0;
    wait_to(t0 + 9);
    rx_v[0] = 1'b1;
    wait_to(t0 + 19);
    chk("glitch_busy_before", bz[0], 1'b1);
    wait_to(t0 + 20);
    chk("glitch_busy_after", bz[0], 1'b0);
    repeat (40) @(negedge clk);
    chk("glitch_no_output", rises[0], r);
    repeat ($urandom_range(1, 30)) @(negedge clk);
    send(0, 8'h5A, 1'b0, 1'b0, 3200);
    chk("after_glitch_data", dout[0], 8'h5A);
    chk("after_glitch_count", rises[0], r + 1);
    chk("after_glitch_flags", {fe[0], pe[0], ov[0]}, 3'b000);
    pulse(0);

    // Overrun, then consume coinciding with the next load.
    send(0, 8'h11, 1'b0, 1'b0, 3200);
    send(0, 8'h22, 1'b0, 1'b0, 3200);
    chk("ovr_data", dout[0], 8'h22);
    chk("ovr_flag", ov[0], 1'b1);
    r = rises[0];
    t0 = cyc + 1;
    fork
      send(0, 8'h33, 1'b0, 1'b0, 3200);
      begin
        wait_to(t0 + 307);
        chk("sim_valid_before", dv[0], 1'b1);
        ready_v[0] = 1'b1;
        wait_to(t0 + 308);
        ready_v[0] = 1'b0;
        chk("sim_valid_after", dv[0], 1'b1);
        chk("sim_data", dout[0], 8'h33);
        chk("sim_overrun", ov[0], 1'b0);
      end
    join
    chk("sim_no_drop", rises[0], r);
    pulse(0);

    // Break: long low yields one zero frame with frame_err, then waits for idle.
    r = rises[0];
    rx_v[0] = 1'b0;
    repeat (960) @(negedge clk);
    chk("brk_count", rises[0], r + 1);
    chk("brk_busy", bz[0], 1'b1);
    chk("brk_frame", {dout[0], fe[0], pe[0], ov[0]}, {8'h00, 3'b100});
    rx_v[0] = 1'b1;
    repeat (40) @(negedge clk);
    chk("brk_idle", bz[0], 1'b0);
    chk("brk_single", rises[0], r + 1);
    pulse(0);
    send(0, 8'h7E, 1'b0, 1'b0, 3200);
    chk("brk_next", {dout[0], fe[0], ov[0]}, {8'h7E, 2'b00});
    chk("brk_next_count", rises[0], r + 2);
    pulse(0);

    // Reset mid-frame discards it; next frame decodes normally.
    r = rises[0];
    t0 = cyc + 1;
    fork
      send(0, 8'hF5, 1'b0, 1'b0, 3200);
      begin
        wait_to(t0 + 4 * 32 + 16);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {dv[0], bz[0]}, 2'b00);
        wait_to(t0 + 5 * 32 + 16);
        rst_n = 1'b1;
      end
    join
    repeat (40) @(negedge clk);
    chk("rst_no_output", rises[0], r);
    chk("rst_idle", bz[0], 1'b0);
    send(0, 8'h3C, 1'b0, 1'b0, 3200);
    chk("rst_next", {dout[0], fe[0], pe[0], ov[0]}, {8'h3C, 3'b000});
    chk("rst_next_count", rises[0], r + 1);
    pulse(0);

    // Parity: even and odd receivers watch the same line.
    for (int n = 0; n < 8; n++) begin
      if (n < 2) begin
        d = 8'h03;
        p = (n == 0);
      end else begin
        d = 8'($urandom);
        p = 1'($urandom);
      end
      ones = $countones(d) + int'(p);
      send(2, d, 1'b1, p, 3200);
      chk($sformatf("par_even_err_%0d", n), pe[2], ((ones % 2) != 0));
      chk($sformatf("par_odd_err_%0d", n), pe[3], ((ones % 2) != 1));
      chk($sformatf("par_even_data_%0d", n), {dout[2], fe[2]}, {d, 1'b0});
      chk($sformatf("par_odd_data_%0d", n), {dout[3], fe[3]}, {d, 1'b0});
      pulse(2);
      pulse(3);
    end

    // All 256 values at +/-3 % baud skew, split over two default receivers.
    fork
      for (int v = 0; v < 128; v++) begin
        send(0, 8'(v), 1'b0, 1'b0, ($urandom_range(0, 1) != 0) ? 3296 : 3104);
        chk($sformatf("skew_a_%0d", v), {dout[0], fe[0], dv[0]}, {8'(v), 2'b01});
        pulse(0);
      end
      for (int v = 128; v < 256; v++) begin
        send(1, 8'(v), 1'b0, 1'b0, ($urandom_range(0, 1) != 0) ? 3296 : 3104);
        chk($sformatf("skew_b_%0d", v), {dout[1], fe[1], dv[1]}, {8'(v), 2'b01});
        pulse(1);
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receiver: the successor to the fixed 8N1 receiver used on the CPU's serial load/debug path. It generalises bit period, data width, parity and stop-bit count, adds majority-vote sampling, start-glitch rejection, framing/parity/overrun detection and a valid/ready output handshake. It sits between the board `rx` pin and the byte consumer (loader FSM or RX FIFO).

## Interface
Parameters:
- CLKS_PER_BIT, 32: clock cycles per UART bit; even, ≥ 8.
- DATA_BITS, 8: data bits per frame, 5..9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  one clock; reset is asynchronous and active-low.
- rx  in  1  asynchronous serial input, idle high.
- data_out  out  DATA_BITS  received word, LSB = first data bit.
- data_valid  out  1  data_out/flags hold an unconsumed frame.
- data_ready  in  1  consumer accepts when data_valid && data_ready.
- frame_err  out  1  a stop bit of the held frame was sampled 0.
- parity_err  out  1  parity mismatch on held frame (always 0 when PARITY = 0).
- overrun  out  1  held frame replaced a previous unconsumed frame.
- busy  out  1  receiver not in IDLE.

## Operation
- `rx` is passed through a 2-flop synchroniser (`rxs`). Both flops reset to 1.
- H = CLKS_PER_BIT/2. A bit counter runs 0..CLKS_PER_BIT-1 per bit, and a bit index counts bits within the current state.
- Each bit is decided by a majority of `rxs` samples taken at counter values H-1, H and H+1. The decision is registered in the following cycle.
- States:
  - IDLE → START when `rxs` = 0; the counter is cleared.
  - START: if the decision is 1 (glitch), go to IDLE and produce no output. Otherwise go to DATA.
  - DATA: DATA_BITS decisions are shifted in LSB-first. Then go to PARITY if PARITY ≠ 0, else to STOP.
  - PARITY: one decision is compared against the XOR of the data bits (even: XOR equals the parity bit; odd: the inverse).
  - STOP: STOP_BITS decisions; any 0 sets frame_err for the frame. After the last stop decision, load the output register.
    - If data = 0 and frame_err = 1 (break), go to BREAK_WAIT.
    - Otherwise go to IDLE. The second half of the last stop bit is not waited for.
  - BREAK_WAIT → IDLE when `rxs` = 1.
- Output register load: data_out, frame_err, parity_err and data_valid = 1 are loaded together.
  - overrun = 1 if data_valid was 1 and not consumed in that same cycle; otherwise overrun = 0.
- Consume (data_valid && data_ready, with no load in that cycle): data_valid → 0. The flags keep their values until the next load.
- Simultaneous consume and load: the new frame is loaded, data_valid stays 1, overrun = 0.
- data_ready is ignored while data_valid = 0.

## Timing
- Reset values: data_out = 0, data_valid = 0, frame_err = 0, parity_err = 0, overrun = 0, busy = 0, state = IDLE, both synchroniser flops = 1.
- Asserting reset mid-frame aborts the frame immediately. Nothing is emitted, and the receiver re-arms only on a fresh falling edge after release.
- Let t0 be the clock edge at which the pin low is first captured, and N = 1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS.
  - The START decision is registered at t0+2+H+2.
  - data_valid rises at t0 + 2 + (N-1)·CLKS_PER_BIT + H + 2.
  - Default 8N1: t0 + 308.
- busy is 1 from the cycle after `rxs` is seen low until the cycle the state returns to IDLE.
- Back-to-back frames with no idle gap are received without loss.
- Tolerated baud mismatch is at least ±3 % at defaults.

## Structure
- Shared package `uart_pkg` holds:
  - parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD);
  - the receiver state enum (IDLE, START, DATA, PARITY, STOP, BREAK_WAIT);
  - a `majority3` function.
- One sub-module, `uart_rx_sync`: the 2-flop synchroniser with parameterised reset value.
- The counters, FSM and output register live in `uart_rx_frame`.

## Test plan
- Defaults, send 0xA5 8N1 at exactly CLKS_PER_BIT → data_out = 0xA5, data_valid rises at t0+308, all flags 0, held until data_ready pulse.
- PARITY = 1, send 0x03 with parity bit 1 → parity_err = 1; with parity bit 0 → parity_err = 0. PARITY = 2 inverts both results.
- 10-cycle low glitch on rx in idle → no data_valid, busy returns to 0 by cycle 20; a following real 0x5A frame is received correctly.
- data_ready held 0, send 0x11 then 0x22 → after the second frame: data_out = 0x22, overrun = 1. Then consume exactly as frame 3 (0x33) completes → data_out = 0x33, data_valid stays 1, overrun = 0.
- rx held low for 30 bit times → one frame with data 0, frame_err = 1. No further frames until rx returns high; the next 0x7E frame is received correctly.
- Reset asserted at bit 4 of a frame, released one bit later while rx is still toggling → no output until the next full valid frame, which decodes correctly; baud skew of ±3 % at 8N1 → all 256 byte values decode correctly.
